prime_sweep_ctrl: RTL and testbench
===================================

PRIME_SWEEP_CTRL -- requirements
Module: prime_sweep_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, ports named clk and reset_n.
REQ-002 Port list SHALL be:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  sweep request, level-sampled
- pause  in  1  freeze sweep while high
- lo  in  4  first value of sweep
- hi  in  4  last value of sweep
- num_out  out  4  value driven to the downstream prime/multiplier indicator
- prime_in  in  1  indicator prime flag for num_out, combinational, same cycle
- mul_in  in  5  indicator multiplier flags for num_out (bit4 = 11, bit3 = 7, bit2 = 5, bit1 = 3, bit0 = 1)
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- prime_cnt  out  5  number of sampled values with prime_in = 1 (0..16)
- max_prime  out  4  largest numeric value sampled with prime_in = 1
- prime_found  out  1  at least one prime sampled
- mul_cnt  out  25  five 5-bit multiplier counters; bits [5k+4:5k] count mul_in[k]

Function
REQ-003 The FSM SHALL have the states IDLE, SWEEP and DONE, encoded in 2 bits.
REQ-004 IDLE: on an edge with start = 1, the FSM SHALL latch lo and hi, load num_out <= lo, clear prime_cnt, max_prime, prime_found and mul_cnt, and enter SWEEP.
REQ-005 SWEEP, edge with pause = 0: the FSM SHALL accumulate prime_in and mul_in for the current num_out, then advance num_out <= num_out + 1 mod 16.
REQ-006 SWEEP, edge with pause = 1: all state and outputs SHALL hold; nothing is accumulated.
REQ-007 At the accumulating edge where num_out equals the latched hi, the FSM SHALL enter DONE; num_out holds at hi.
REQ-008 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-009 busy SHALL be 1 in SWEEP only; done SHALL be 1 in DONE only.
REQ-010 Sweep length SHALL be ((hi - lo) mod 16) + 1 accumulating edges.
- lo = hi: one value.
- lo > hi: the sweep wraps 15 -> 0.
- Maximum length is 16 values.
REQ-011 Accumulate rules:
- prime_in = 1: prime_cnt increments and prime_found <= 1.
- prime_in = 1 and num_out > max_prime (or prime_found = 0): max_prime <= num_out.
REQ-012 prime_cnt and every mul_cnt field SHALL saturate at 16; they cannot exceed 16 by construction.
REQ-013 start SHALL be ignored in SWEEP and DONE; lo and hi changes during a sweep SHALL have no effect.
REQ-014 Results SHALL hold after DONE until the next accepted start.

Reset
REQ-015 While reset_n = 0, asynchronously:
- state = IDLE
- num_out, prime_cnt, max_prime, mul_cnt = 0
- busy, done, prime_found = 0
REQ-016 Reset asserted mid-sweep SHALL abort the sweep without a done pulse; the first edge after release evaluates start from IDLE.

Configuration
REQ-017 With macro PRIME_SWEEP_MUL_CNT_EN defined, the five mul_cnt counters SHALL be implemented per REQ-005 and REQ-012.
REQ-018 Without PRIME_SWEEP_MUL_CNT_EN, mul_cnt SHALL be constant 0 and mul_in SHALL be ignored; all other behaviour is unchanged.

Verification
REQ-019 The bench SHALL pair the block with an ideal indicator model (prime, multiples of 11/7/5/3) and cover:
- lo = 0, hi = 15, no pause -> 16 accumulating edges, done one cycle after the last; prime_cnt = 6, max_prime = 13, prime_found = 1; with the macro, mul_cnt fields 4..1 = 1, 2, 3, 5.
- lo = 14, hi = 2 (wrap) -> num_out 14, 15, 0, 1, 2; 5 edges; prime_cnt = 1, max_prime = 2.
- lo = hi = 7 -> one accumulating edge; prime_cnt = 1, max_prime = 7; done on the next cycle.
- lo = 8, hi = 10, pause high for 3 cycles mid-sweep -> counts identical to the unpaused run (prime_cnt = 0, prime_found = 0); busy extended by 3 cycles.
- reset_n low during a 0..15 sweep -> all outputs 0 immediately, no done pulse; a start pulse during DONE is ignored.

Source files
------------

// File: rtl/prime_sweep_ctrl.sv
// Sweeps num_out from lo to hi (mod 16), tallying prime/multiplier flags from an external indicator.
// Optional: define PRIME_SWEEP_MUL_CNT_EN to implement the five mul_cnt counters (otherwise tied to 0).
module prime_sweep_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pause,
  input  logic [3:0]  lo,
  input  logic [3:0]  hi,
  output logic [3:0]  num_out,
  input  logic        prime_in,
  input  logic [4:0]  mul_in,
  output logic        busy,
  output logic        done,
  output logic [4:0]  prime_cnt,
  output logic [3:0]  max_prime,
  output logic        prime_found,
  output logic [24:0] mul_cnt
);

  localparam int unsigned NUM_W   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned MUL_N   = 5;
  localparam int unsigned CNT_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [NUM_W-1:0] r_hi;
  logic             w_accept;
  logic             w_accum;
  logic             w_last;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_accum  = (r_state == ST_SWEEP) && !pause;
  assign w_last   = (num_out == r_hi);

  // Sequencer and prime accumulators; every output is a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_hi        <= '0;
      num_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prime_cnt   <= '0;
      max_prime   <= '0;
      prime_found <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (w_accept) begin
            r_hi        <= hi;
            num_out     <= lo;
            prime_cnt   <= '0;
            max_prime   <= '0;
            prime_found <= 1'b0;
            busy        <= 1'b1;
            r_state     <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (w_accum) begin
            if (prime_in) begin
              if (prime_cnt < CNT_W'(CNT_MAX)) begin
                prime_cnt <= prime_cnt + CNT_W'(1);
              end
              // First prime always wins; later ones only if larger.
              if (!prime_found || (num_out > max_prime)) begin
                max_prime <= num_out;
              end
              prime_found <= 1'b1;
            end
            if (w_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              num_out <= num_out + NUM_W'(1);
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PRIME_SWEEP_MUL_CNT_EN
  // Five saturating tallies, one per multiplier flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_cnt <= '0;
    end else if (w_accept) begin
      mul_cnt <= '0;
    end else if (w_accum) begin
      for (int k = 0; k < int'(MUL_N); k++) begin
        if (mul_in[k] && (mul_cnt[CNT_W*k +: CNT_W] < CNT_W'(CNT_MAX))) begin
          mul_cnt[CNT_W*k +: CNT_W] <= mul_cnt[CNT_W*k +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`else
  logic w_unused_mul;

  assign mul_cnt      = '0;
  assign w_unused_mul = ^{mul_in, MUL_N'(0)};
`endif

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Bench for prime_sweep_ctrl: ideal prime/multiple indicator plus a result scoreboard.
module tb_prime_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        pause;
  logic [3:0]  lo;
  logic [3:0]  hi;
  logic [3:0]  num_out;
  logic        prime_in;
  logic [4:0]  mul_in;
  logic        busy;
  logic        done;
  logic [4:0]  prime_cnt;
  logic [3:0]  max_prime;
  logic        prime_found;
  logic [24:0] mul_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          edges;
    logic [4:0]  pc;
    logic [3:0]  mp;
    logic        pf;
    logic [24:0] mc;
  } exp_t;

  exp_t sb_q[$];

  prime_sweep_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .pause      (pause),
    .lo         (lo),
    .hi         (hi),
    .num_out    (num_out),
    .prime_in   (prime_in),
    .mul_in     (mul_in),
    .busy       (busy),
    .done       (done),
    .prime_cnt  (prime_cnt),
    .max_prime  (max_prime),
    .prime_found(prime_found),
    .mul_cnt    (mul_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic is_prime(input logic [3:0] v);
    case (v)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic int divisor(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 5;
      3:       return 7;
      default: return 11;
    endcase
  endfunction

  function automatic logic [4:0] mul_flags(input logic [3:0] v);
    logic [4:0] f;
    f = '0;
    for (int k = 0; k < 5; k++) begin
      if ((v != 4'd0) && ((int'(v) % divisor(k)) == 0)) f[k] = 1'b1;
    end
    return f;
  endfunction

  // Ideal indicator: combinational response to num_out.
  always_comb begin
    prime_in = is_prime(num_out);
    mul_in   = mul_flags(num_out);
  end

  function automatic exp_t model(input logic [3:0] l, input logic [3:0] h);
    exp_t       e;
    logic [3:0] v;
    logic [4:0] f;
    logic [3:0] d;
    e.pc = '0; e.mp = '0; e.pf = 1'b0; e.mc = '0;
    d       = h - l;
    e.edges = int'(d) + 1;
    v       = l;
    for (int n = 0; n < e.edges; n++) begin
      if (is_prime(v)) begin
        if (!e.pf || (v > e.mp)) e.mp = v;
        e.pc = e.pc + 5'd1;
        e.pf = 1'b1;
      end
`ifdef PRIME_SWEEP_MUL_CNT_EN
      f = mul_flags(v);
      for (int k = 0; k < 5; k++) begin
        if (f[k]) e.mc[5*k +: 5] = e.mc[5*k +: 5] + 5'd1;
      end
`else
      f = '0;
`endif
      v = v + 4'd1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One sweep: drive start, walk the sweep with an optional pause window, score on done.
  task automatic run_sweep(input logic [3:0] l, input logic [3:0] h,
                           input int pause_at, input int pause_len, input bit start_in_done);
    exp_t       e;
    logic [3:0] v;
    int         cyc;
    int         acc;
    @(negedge clk);
    lo = l; hi = h; start = 1'b1;
    sb_q.push_back(model(l, h));
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_num", 32'(num_out), 32'(l));
    v = l; cyc = 0; acc = 0;
    while (busy && (cyc < 40)) begin
      pause = (pause_len > 0) && (cyc >= pause_at) && (cyc < pause_at + pause_len);
      if (!pause) begin
        check("seq_num", 32'(num_out), 32'(v));
        v = v + 4'd1;
        acc++;
      end
      lo = 4'($urandom_range(15));
      hi = 4'($urandom_range(15));
      cyc++;
      @(negedge clk);
    end
    pause = 1'b0;
    if (cyc >= 40) check("sweep_timeout", 32'd1, 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("hold_num", 32'(num_out), 32'(h));
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("edges", 32'(acc), 32'(e.edges));
      check("busy_cycles", 32'(cyc), 32'(e.edges + pause_len));
      check("prime_cnt", 32'(prime_cnt), 32'(e.pc));
      check("max_prime", 32'(max_prime), 32'(e.mp));
      check("prime_found", 32'(prime_found), 32'(e.pf));
      check("mul_cnt", 32'(mul_cnt), 32'(e.mc));
      if (start_in_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_single", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("still_idle", 32'(busy), 32'd0);
      check("result_hold", 32'(prime_cnt), 32'(e.pc));
    end
  endtask

  int saw_done;

  initial begin
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; lo = '0; hi = '0;
    #1;
    check("rst_num", 32'(num_out), 32'd0);
    check("rst_flags", 32'({busy, done, prime_found}), 32'd0);
    check("rst_cnt", 32'(prime_cnt), 32'd0);
    check("rst_max", 32'(max_prime), 32'd0);
    check("rst_mul", 32'(mul_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_sweep(4'd0,  4'd15, 0, 0, 1'b0);
    run_sweep(4'd14, 4'd2,  0, 0, 1'b0);
    run_sweep(4'd7,  4'd7,  0, 0, 1'b1);
    run_sweep(4'd8,  4'd10, 1, 3, 1'b0);
    run_sweep(4'd13, 4'd3,  2, 2, 1'b0);

    // Reset during a full sweep: immediate clear and no done pulse.
    @(negedge clk);
    lo = 4'd0; hi = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_num", 32'(num_out), 32'd0);
    check("abort_flags", 32'({busy, done, prime_found}), 32'd0);
    check("abort_cnt", 32'(prime_cnt), 32'd0);
    check("abort_max", 32'(max_prime), 32'd0);
    check("abort_mul", 32'(mul_cnt), 32'd0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    lo = 4'd3; hi = 4'd3; start = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (done) saw_done++;
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("post_rst_start", 32'(busy), 32'd1);
    check("post_rst_num", 32'(num_out), 32'd3);
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_prime", 32'(max_prime), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
